// File: rtl/cache_pkg.sv
// Shared cache constants and elaboration helpers for the replacement trackers.
package cache_pkg;

   localparam int WAYS_8 = 8;
   localparam int WAYS_4 = 4;
   localparam int WAYS_2 = 2;

   // Smallest r with 2**r >= value; gives the PLRU tree depth from the way count.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int p = 1; p < value; p = p * 2) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU core: victim walk and next tree bits for one set.
// Tree bit for heap node n lives at i_tree[n-1]; the root is node 1.
module plru_tree_logic
   import cache_pkg::*;
#(
   parameter int CACHE_WAY = WAYS_8
) (
   input  logic [CACHE_WAY-2:0] i_tree,
   input  logic [CACHE_WAY-1:0] i_way,
   output logic [CACHE_WAY-1:0] o_victim,
   output logic [CACHE_WAY-2:0] o_next_tree
);

   localparam int DEPTH = clog2(CACHE_WAY);

   // One reach vector per level keeps the walk free of combinational self-loops.
   for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
      logic [(1<<l)-1:0] w_reach;
      if (l == 0) begin : g_root
         assign w_reach = 1'b1;
      end else begin : g_walk
         for (genvar j = 0; j < (1 << l); j++) begin : g_bit
            localparam int PIDX = (1 << (l - 1)) - 1 + j / 2;
            if (j % 2 == 1) begin : g_hi
               assign w_reach[j] = g_lvl[l-1].w_reach[j/2] & i_tree[PIDX];
            end else begin : g_lo
               assign w_reach[j] = g_lvl[l-1].w_reach[j/2] & ~i_tree[PIDX];
            end
         end
      end
   end

   assign o_victim = g_lvl[DEPTH].w_reach;

   // Multi-hot access vectors collapse to their lowest set bit.
   logic [CACHE_WAY-1:0] w_low;
   logic [DEPTH-1:0]     w_idx;
   logic                 w_any;

   assign w_low = i_way & (-i_way);
   assign w_any = |i_way;

   for (genvar b = 0; b < DEPTH; b++) begin : g_idx
      logic [CACHE_WAY-1:0] w_mask;
      for (genvar i = 0; i < CACHE_WAY; i++) begin : g_mask
         assign w_mask[i] = ((i >> b) % 2) == 1;
      end
      assign w_idx[b] = |(w_low & w_mask);
   end

   for (genvar n = 1; n < CACHE_WAY; n++) begin : g_node
      localparam int LVL = clog2(n + 1) - 1;
      localparam logic [DEPTH-1:0] OFF = DEPTH'(n - (1 << LVL));
      logic w_on_path;
      assign w_on_path = (w_idx >> (DEPTH - LVL)) == OFF;
      assign o_next_tree[n-1] = (w_any && w_on_path) ? ~w_idx[DEPTH-1-LVL] : i_tree[n-1];
   end

endmodule

// File: rtl/eightway_plru.sv
// Per-set pseudo-LRU replacement tracker: holds one PLRU tree per set and
// reports the one-hot victim of the addressed set with zero read latency.
module eightway_plru
   import cache_pkg::*;
#(
   parameter int CACHE_WAY  = WAYS_8,
   parameter int INDEX_BITS = 3
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [INDEX_BITS-1:0] i_index,
   input  logic                  i_hit,
   input  logic [CACHE_WAY-1:0]  i_way_accessed,
   output logic [CACHE_WAY-1:0]  o_LRU
);

   localparam int TREE_BITS = CACHE_WAY - 1;
   localparam int SETS      = 1 << INDEX_BITS;

   if (!(CACHE_WAY == WAYS_8 || CACHE_WAY == WAYS_4 || CACHE_WAY == WAYS_2)) begin : g_bad_way
      $error("eightway_plru: CACHE_WAY must be 2, 4 or 8");
   end

   logic [TREE_BITS-1:0] r_tree [0:SETS-1];
   logic [TREE_BITS-1:0] w_cur_tree;
   logic [TREE_BITS-1:0] w_next_tree;

   assign w_cur_tree = r_tree[i_index];

   plru_tree_logic #(
      .CACHE_WAY (CACHE_WAY)
   ) u_tree (
      .i_tree      (w_cur_tree),
      .i_way       (i_way_accessed),
      .o_victim    (o_LRU),
      .o_next_tree (w_next_tree)
   );

   // NOTE: the tree store is a flop array rather than a RAM macro, so every set
   // can be cleared in the single reset cycle; a RAM would need a clear sweep.
   // NOTE: non-blocking assignments keep the read of w_cur_tree (old state)
   // consistent with the write of the same set on this edge.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_tree <= '{default: '0};
      end else if (i_hit) begin
         r_tree[i_index] <= w_next_tree;
      end
   end

endmodule

// File: tb/tb_eightway_plru.sv
// Bench for eightway_plru: 8/4/2-way instances share stimulus; a heap-walk
// model of the replacement trees is compared every cycle, plus literal checks.
module tb_eightway_plru;

   logic       clk = 1'b0;
   logic       nrst;
   logic [2:0] i_index;
   logic       i_hit;
   logic [7:0] way8;
   logic [3:0] way4;
   logic [1:0] way2;
   logic [7:0] lru8;
   logic [3:0] lru4;
   logic [1:0] lru2;

   int n_checks = 0;
   int n_errors = 0;
   bit started  = 1'b0;

   // Model: m[k][set][node], k=0 -> 8 ways, 1 -> 4 ways, 2 -> 2 ways; node 1 is the root.
   bit m [3][8][8];

   always #5 clk = ~clk;

   assign way4 = way8[3:0];
   assign way2 = way8[1:0];

   eightway_plru #(.CACHE_WAY(8), .INDEX_BITS(3)) u_dut8 (
      .clk (clk), .nrst (nrst), .i_index (i_index), .i_hit (i_hit),
      .i_way_accessed (way8), .o_LRU (lru8));

   eightway_plru #(.CACHE_WAY(4), .INDEX_BITS(3)) u_dut4 (
      .clk (clk), .nrst (nrst), .i_index (i_index), .i_hit (i_hit),
      .i_way_accessed (way4), .o_LRU (lru4));

   eightway_plru #(.CACHE_WAY(2), .INDEX_BITS(3)) u_dut2 (
      .clk (clk), .nrst (nrst), .i_index (i_index), .i_hit (i_hit),
      .i_way_accessed (way2), .o_LRU (lru2));

   function automatic int ways_of(int k);
      return 8 >> k;
   endfunction

   function automatic logic [7:0] model_victim(int k, int idx);
      int node;
      node = 1;
      while (node < ways_of(k)) node = 2 * node + int'(m[k][idx][node]);
      return 8'(1 << (node - ways_of(k)));
   endfunction

   function automatic logic [7:0] actual_of(int k);
      if (k == 0) return lru8;
      if (k == 1) return {4'h0, lru4};
      return {6'h00, lru2};
   endfunction

   // Applies the sampled inputs of the edge that just occurred to the model.
   task automatic model_apply();
      int w, d, node, idx;
      logic [7:0] vec;
      if (!nrst) begin
         for (int k = 0; k < 3; k++)
            for (int s = 0; s < 8; s++)
               for (int n = 0; n < 8; n++) m[k][s][n] = 1'b0;
      end else if (i_hit) begin
         idx = int'(i_index);
         for (int k = 0; k < 3; k++) begin
            vec = way8 & 8'((1 << ways_of(k)) - 1);
            if (vec != 8'h00) begin
               w = 0;
               for (int b = 7; b >= 0; b--) if (vec[b]) w = b;
               d = 3 - k;
               for (int l = 0; l < d; l++) begin
                  node = (1 << l) | (w >> (d - l));
                  m[k][idx][node] = (((w >> (d - 1 - l)) % 2) == 0);
               end
            end
         end
      end
   endtask

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(bit rstn, int idx, bit hit, logic [7:0] way);
      nrst    = rstn;
      i_index = 3'(idx);
      i_hit   = hit;
      way8    = way;
      @(posedge clk);
      model_apply();
      #1;
   endtask

   task automatic expect_at(string name, int k, int idx, logic [7:0] exp);
      @(negedge clk);
      nrst    = 1'b1;
      i_hit   = 1'b0;
      i_index = 3'(idx);
      #1;
      check(name, actual_of(k), exp);
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("model8", actual_of(0), model_victim(0, int'(i_index)));
         check("model4", actual_of(1), model_victim(1, int'(i_index)));
         check("model2", actual_of(2), model_victim(2, int'(i_index)));
      end
   end

   initial begin
      nrst = 1'b0; i_index = 3'd0; i_hit = 1'b0; way8 = 8'h00;

      // Reset, with a simultaneous hit that must be ignored.
      drive(1'b0, 0, 1'b1, 8'h01);
      started = 1'b1;
      for (int s = 0; s < 8; s++) expect_at("reset8", 0, s, 8'h01);
      expect_at("reset4", 1, 0, 8'h01);
      expect_at("reset2", 2, 0, 8'h01);

      // Single accesses on set 0.
      drive(1'b1, 0, 1'b1, 8'h01);
      expect_at("acc_w0_8", 0, 0, 8'h10);
      expect_at("acc_w0_4", 1, 0, 8'h04);
      expect_at("acc_w0_2", 2, 0, 8'h02);
      drive(1'b1, 0, 1'b1, 8'h10);
      expect_at("acc_w4_8", 0, 0, 8'h04);

      // Touch every way in order: the oldest, way 0, becomes the victim.
      for (int w = 0; w < 8; w++) drive(1'b1, 0, 1'b1, 8'(1 << w));
      expect_at("sweep8", 0, 0, 8'h01);
      drive(1'b1, 0, 1'b0, 8'h01);
      expect_at("nohit8", 0, 0, 8'h01);

      // Set isolation, then reset priority over a simultaneous hit.
      drive(1'b1, 2, 1'b1, 8'h01);
      expect_at("iso_idx2", 0, 2, 8'h10);
      expect_at("iso_idx3", 0, 3, 8'h01);
      drive(1'b0, 2, 1'b1, 8'h01);
      expect_at("rstprio", 0, 2, 8'h01);

      // Malformed access vectors.
      drive(1'b1, 4, 1'b1, 8'h0C);
      expect_at("multihot", 0, 4, 8'h10);
      drive(1'b1, 4, 1'b1, 8'h00);
      expect_at("zeroway", 0, 4, 8'h10);

      // Smaller associativities.
      drive(1'b1, 5, 1'b1, 8'h01);
      expect_at("w4_acc0", 1, 5, 8'h04);
      drive(1'b1, 5, 1'b1, 8'h04);
      expect_at("w4_acc2", 1, 5, 8'h02);
      drive(1'b1, 6, 1'b1, 8'h01);
      expect_at("w2_acc0", 2, 6, 8'h02);
      drive(1'b1, 6, 1'b1, 8'h02);
      expect_at("w2_acc1", 2, 6, 8'h01);

      // Randomised traffic: mostly one-hot hits, some multi-hot/zero, rare resets.
      for (int c = 0; c < 3000; c++) begin
         int mode;
         logic [7:0] way;
         mode = int'($urandom_range(0, 9));
         if (mode < 7)       way = 8'(1 << $urandom_range(0, 7));
         else if (mode < 9)  way = 8'($urandom_range(0, 255));
         else                way = 8'h00;
         drive($urandom_range(0, 63) != 0, int'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0, way);
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
